// File: rtl/load_store_unit_if.sv
// Core request/response signals and the word-wide data-memory port of the load/store unit.
// The LSU uses the master view; the core and memory use the slave view.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_write;
    logic [2:0]            req_f3;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [31:0]           req_wdata;
    logic                  stall;
    logic                  done;
    logic [31:0]           load_data;
    logic                  misaligned;
    logic                  timeout;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_write;
    logic [3:0]            mem_wstrb;
    logic [31:0]           mem_wdata;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    modport master (
        input  req_valid, req_write, req_f3, req_address, req_wdata,
               mem_ready, mem_rvalid, mem_rdata,
        output stall, done, load_data, misaligned, timeout,
               mem_valid, mem_address, mem_write, mem_wstrb, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_f3, req_address, req_wdata,
               mem_ready, mem_rvalid, mem_rdata,
        input  stall, done, load_data, misaligned, timeout,
               mem_valid, mem_address, mem_write, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store decode into word-wide memory requests with strobes,
// extends load results, stalls the core until completion and reports misalignment/timeouts.
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    localparam logic [31:0] TimeoutLimit = 32'(TIMEOUT_CYCLES);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic                  mem_write_q, mem_write_d;
    logic [3:0]            mem_wstrb_q, mem_wstrb_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [31:0]           load_data_q, load_data_d;
    logic                  misaligned_q, misaligned_d;
    logic                  timeout_q, timeout_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           count_q, count_d;

    logic        f3_legal, f3_aligned;
    logic        start_ok, start_err, accept, respond, expired, abort;
    logic [3:0]  store_strb;
    logic [31:0] store_data;
    logic [31:0] byte_shift, half_shift, load_ext;

    always_comb begin
        f3_legal   = 1'b0;
        f3_aligned = 1'b0;
        case (bus.req_f3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !bus.req_write;
            default:                f3_legal = 1'b0;
        endcase
        case (bus.req_f3[1:0])
            2'b00:   f3_aligned = 1'b1;
            2'b01:   f3_aligned = !bus.req_address[0];
            2'b10:   f3_aligned = (bus.req_address[1:0] == 2'b00);
            default: f3_aligned = 1'b0;
        endcase
    end

    // Stores replicate the datum across every lane so the strobe alone picks the bytes written.
    always_comb begin
        store_strb = 4'b0000;
        store_data = bus.req_wdata;
        if (bus.req_write) begin
            case (bus.req_f3[1:0])
                2'b00: begin
                    store_strb = 4'b0001 << bus.req_address[1:0];
                    store_data = {4{bus.req_wdata[7:0]}};
                end
                2'b01: begin
                    store_strb = 4'b0011 << {bus.req_address[1], 1'b0};
                    store_data = {2{bus.req_wdata[15:0]}};
                end
                default: begin
                    store_strb = 4'b1111;
                    store_data = bus.req_wdata;
                end
            endcase
        end
    end

    always_comb begin
        byte_shift = bus.mem_rdata >> {lane_q, 3'b000};
        half_shift = bus.mem_rdata >> {lane_q[1], 4'b0000};
        case (f3_q)
            3'b000:  load_ext = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'b001:  load_ext = {{16{half_shift[15]}}, half_shift[15:0]};
            3'b100:  load_ext = {24'h000000, byte_shift[7:0]};
            3'b101:  load_ext = {16'h0000, half_shift[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // Completion by the memory always wins over an expiring timeout in the same cycle.
    assign start_ok  = (state_q == IDLE) && bus.req_valid && f3_legal && f3_aligned;
    assign start_err = (state_q == IDLE) && bus.req_valid && !(f3_legal && f3_aligned);
    assign accept    = (state_q == REQ) && bus.mem_ready;
    assign respond   = (state_q == WAIT) && bus.mem_rvalid;
    assign expired   = (TIMEOUT_CYCLES != 0) && ((count_q + 32'd1) >= TimeoutLimit);
    assign abort     = expired && (((state_q == REQ) && !bus.mem_ready) ||
                                   ((state_q == WAIT) && !bus.mem_rvalid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = REQ;
                end else if (start_err) begin
                    state_d = DONE;
                end
            end
            REQ: begin
                if (accept) begin
                    state_d = mem_write_q ? DONE : WAIT;
                end else if (abort) begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (respond || abort) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_address_d = mem_address_q;
        mem_write_d   = mem_write_q;
        mem_wstrb_d   = mem_wstrb_q;
        mem_wdata_d   = mem_wdata_q;
        load_data_d   = load_data_q;
        f3_d          = f3_q;
        lane_d        = lane_q;
        count_d       = count_q;
        misaligned_d  = 1'b0;
        timeout_d     = 1'b0;
        if (start_ok) begin
            mem_address_d = {bus.req_address[ADDR_WIDTH-1:2], 2'b00};
            mem_write_d   = bus.req_write;
            mem_wstrb_d   = store_strb;
            mem_wdata_d   = store_data;
            f3_d          = bus.req_f3;
            lane_d        = bus.req_address[1:0];
            count_d       = 32'd0;
        end
        if (start_err) begin
            misaligned_d = 1'b1;
            load_data_d  = 32'd0;
        end
        if ((state_q == REQ) || (state_q == WAIT)) begin
            count_d = count_q + 32'd1;
        end
        if (respond) begin
            load_data_d = load_ext;
        end
        if (abort) begin
            timeout_d   = 1'b1;
            load_data_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_address_q <= '0;
            mem_write_q   <= 1'b0;
            mem_wstrb_q   <= 4'b0000;
            mem_wdata_q   <= 32'd0;
            load_data_q   <= 32'd0;
            misaligned_q  <= 1'b0;
            timeout_q     <= 1'b0;
            f3_q          <= 3'b000;
            lane_q        <= 2'b00;
            count_q       <= 32'd0;
        end else begin
            mem_address_q <= mem_address_d;
            mem_write_q   <= mem_write_d;
            mem_wstrb_q   <= mem_wstrb_d;
            mem_wdata_q   <= mem_wdata_d;
            load_data_q   <= load_data_d;
            misaligned_q  <= misaligned_d;
            timeout_q     <= timeout_d;
            f3_q          <= f3_d;
            lane_q        <= lane_d;
            count_q       <= count_d;
        end
    end

    // mem_valid and done decode straight from the state so reset removes them immediately.
    always_comb begin
        bus.mem_valid   = (state_q == REQ);
        bus.done        = (state_q == DONE);
        bus.stall       = bus.req_valid && (state_q != DONE);
        bus.mem_address = mem_address_q;
        bus.mem_write   = mem_write_q;
        bus.mem_wstrb   = mem_wstrb_q;
        bus.mem_wdata   = mem_wdata_q;
        bus.load_data   = load_data_q;
        bus.misaligned  = misaligned_q;
        bus.timeout     = timeout_q;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a word-array memory with configurable latency, a per-access
// expectation model checked every cycle, and literal values for the documented scenarios.
module tb_load_store_unit;
    localparam int AW = 32;
    localparam int TO = 8;

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        isErr;
        logic [31:0] wordAddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

    load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          failures  = 0;
    logic [31:0] memArr [0:63];
    txn_t        cur;
    bit          curActive  = 1'b0;
    bit          curTimeout = 1'b0;
    logic [31:0] lastLoad   = 32'h0;
    int          readyDelay = 0;
    bit          noRvalid   = 1'b0;
    int          lateReq    = 0;
    logic [31:0] lastAddr   = 32'h0;
    logic [31:0] lastWdata  = 32'h0;
    logic [3:0]  lastStrb   = 4'h0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
        end
    endtask

    function automatic txn_t makeTxn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] d);
        txn_t        t;
        logic [31:0] nbytes;
        logic [31:0] laneMask;
        bit          legal;
        nbytes     = 32'd1 << f3[1:0];
        legal      = w ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        t.write    = w;
        t.f3       = f3;
        t.addr     = a;
        t.isErr    = !legal || ((a % nbytes) != 32'd0);
        t.wordAddr = a & 32'hFFFF_FFFC;
        laneMask   = ((32'd1 << nbytes) - 32'd1) << (a % 32'd4);
        t.strb     = w ? laneMask[3:0] : 4'h0;
        if (nbytes == 32'd1)      t.wdata = (d & 32'hFF) * 32'h0101_0101;
        else if (nbytes == 32'd2) t.wdata = (d & 32'hFFFF) * 32'h0001_0001;
        else                      t.wdata = d;
        return t;
    endfunction

    function automatic logic [31:0] loadResult(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        logic [31:0] nbytes;
        logic [31:0] mask;
        logic [31:0] v;
        nbytes = 32'd1 << f3[1:0];
        mask   = (nbytes == 32'd4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        v      = (word >> (8 * (a % 32'd4))) & mask;
        if (!f3[2] && (nbytes < 32'd4) && (v >= (32'd1 << (8 * nbytes - 1)))) v = v | ~mask;
        return v;
    endfunction

    // Memory responder: ready after readyDelay cycles of mem_valid, read data the cycle after acceptance.
    initial begin
        bit          hsValid, hsWrite, rdPending;
        logic [31:0] hsAddr, hsWdata, rdAddr;
        logic [3:0]  hsStrb;
        int          readyCnt, lateServed;
        hsValid = 0; hsWrite = 0; rdPending = 0; hsAddr = 0; hsWdata = 0; rdAddr = 0; hsStrb = 0;
        readyCnt = 0; lateServed = 0;
        for (int i = 0; i < 64; i++) memArr[i] = 32'h0;
        memArr[8] = 32'h80FF_7F01;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bus.mem_ready  = 1'b0;
                bus.mem_rvalid = 1'b0;
                hsValid = 0; rdPending = 0; readyCnt = readyDelay;
            end else begin
                if (hsValid && bus.mem_ready) begin
                    if (hsWrite) begin
                        for (int b = 0; b < 4; b++)
                            if (hsStrb[b]) memArr[hsAddr[7:2]][8*b +: 8] = hsWdata[8*b +: 8];
                        lastAddr = hsAddr; lastWdata = hsWdata; lastStrb = hsStrb;
                    end else if (!noRvalid) begin
                        rdPending = 1; rdAddr = hsAddr;
                    end
                end
                bus.mem_rvalid = 1'b0;
                if (lateReq != lateServed) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = 32'hCAFE_F00D;
                    lateServed     = lateReq;
                end else if (rdPending) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = memArr[rdAddr[7:2]];
                    rdPending      = 0;
                end
                hsValid = bus.mem_valid; hsWrite = bus.mem_write; hsAddr = bus.mem_address;
                hsStrb  = bus.mem_wstrb; hsWdata = bus.mem_wdata;
                if (bus.mem_valid) begin
                    if (readyCnt > 0) begin
                        bus.mem_ready = 1'b0;
                        readyCnt--;
                    end else begin
                        bus.mem_ready = 1'b1;
                    end
                end else begin
                    bus.mem_ready = 1'b0;
                    readyCnt      = readyDelay;
                end
            end
        end
    end

    // Every cycle: request fields while mem_valid, and the result/flags whenever done pulses.
    initial begin
        logic [31:0] expLd;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lastLoad = 32'h0;
            end else begin
                if (bus.mem_valid) begin
                    if (!curActive || cur.isErr) begin
                        checkOutput("unexpected_mem_valid", {31'b0, bus.mem_valid}, 32'h0);
                    end else begin
                        checkOutput("mem_address", bus.mem_address, cur.wordAddr);
                        checkOutput("mem_write", {31'b0, bus.mem_write}, {31'b0, cur.write});
                        checkOutput("mem_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, cur.strb});
                        if (cur.write) checkOutput("mem_wdata", bus.mem_wdata, cur.wdata);
                    end
                end
                if (bus.done) begin
                    if (!curActive) begin
                        checkOutput("unexpected_done", {31'b0, bus.done}, 32'h0);
                    end else begin
                        if (cur.isErr || curTimeout) expLd = 32'h0;
                        else if (cur.write)          expLd = lastLoad;
                        else                         expLd = loadResult(cur.f3, cur.addr, memArr[cur.addr[7:2]]);
                        checkOutput("model_load_data", bus.load_data, expLd);
                        checkOutput("model_misaligned", {31'b0, bus.misaligned}, {31'b0, cur.isErr});
                        checkOutput("model_timeout", {31'b0, bus.timeout}, {31'b0, curTimeout});
                        lastLoad = expLd;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, input bit expTo, output int cycles,
                                 output logic [31:0] ldOut, output logic misOut, output logic tmoOut);
        bit finished;
        cur        = makeTxn(w, f3, a, d);
        curTimeout = expTo;
        cycles = 0; finished = 0; ldOut = 32'h0; misOut = 1'b0; tmoOut = 1'b0;
        @(posedge clk);
        #1;
        curActive       = 1'b1;
        bus.req_write   = w;
        bus.req_f3      = f3;
        bus.req_address = a;
        bus.req_wdata   = d;
        bus.req_valid   = 1'b1;
        while (!finished && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (bus.done) begin
                checkOutput("stall_at_done", {31'b0, bus.stall}, 32'h0);
                ldOut = bus.load_data; misOut = bus.misaligned; tmoOut = bus.timeout;
                finished = 1;
            end else begin
                checkOutput("stall_busy", {31'b0, bus.stall}, 32'h1);
            end
        end
        if (!finished) checkOutput("done_within_budget", {31'b0, finished}, 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        curActive     = 1'b0;
    endtask

    initial begin
        int          cyc;
        int          doneSeen;
        logic [31:0] ld;
        logic        mis, tmo;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_f3 = 3'b000;
        bus.req_address = 32'h0; bus.req_wdata = 32'h0;
        #2;
        checkOutput("rst_mem_valid", {31'b0, bus.mem_valid}, 32'h0);
        checkOutput("rst_done", {31'b0, bus.done}, 32'h0);
        checkOutput("rst_stall", {31'b0, bus.stall}, 32'h0);
        checkOutput("rst_load_data", bus.load_data, 32'h0);
        checkOutput("rst_wstrb", {28'b0, bus.mem_wstrb}, 32'h0);
        checkOutput("rst_mem_address", bus.mem_address, 32'h0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, cyc, ld, mis, tmo);
        checkOutput("sw_latency", cyc, 32'd3);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, cyc, ld, mis, tmo);
        checkOutput("lw_data", ld, 32'hDEAD_BEEF);
        checkOutput("lw_latency", cyc, 32'd4);

        applyStimulus(1'b0, 3'b000, 32'h23, 32'h0, 1'b0, cyc, ld, mis, tmo);
        checkOutput("lb_data", ld, 32'hFFFF_FF80);
        applyStimulus(1'b0, 3'b100, 32'h23, 32'h0, 1'b0, cyc, ld, mis, tmo);
        checkOutput("lbu_data", ld, 32'h0000_0080);
        applyStimulus(1'b0, 3'b001, 32'h22, 32'h0, 1'b0, cyc, ld, mis, tmo);
        checkOutput("lh_data", ld, 32'hFFFF_80FF);
        applyStimulus(1'b0, 3'b101, 32'h20, 32'h0, 1'b0, cyc, ld, mis, tmo);
        checkOutput("lhu_data", ld, 32'h0000_7F01);

        applyStimulus(1'b1, 3'b000, 32'h31, 32'h1234_56AB, 1'b0, cyc, ld, mis, tmo);
        checkOutput("sb_wstrb", {28'b0, lastStrb}, 32'h2);
        checkOutput("sb_wdata", lastWdata, 32'hABAB_ABAB);
        checkOutput("sb_address", lastAddr, 32'h30);
        checkOutput("store_keeps_load_data", ld, 32'h0000_7F01);
        applyStimulus(1'b1, 3'b001, 32'h32, 32'hFFFF_1234, 1'b0, cyc, ld, mis, tmo);
        checkOutput("sh_wstrb", {28'b0, lastStrb}, 32'hC);
        checkOutput("sh_wdata", lastWdata, 32'h1234_1234);
        applyStimulus(1'b0, 3'b010, 32'h30, 32'h0, 1'b0, cyc, ld, mis, tmo);
        checkOutput("merged_word", ld, 32'h1234_AB00);

        applyStimulus(1'b0, 3'b010, 32'h41, 32'h0, 1'b0, cyc, ld, mis, tmo);
        checkOutput("lw_misaligned_flag", {31'b0, mis}, 32'h1);
        checkOutput("lw_misaligned_data", ld, 32'h0);
        checkOutput("misaligned_latency", cyc, 32'd2);
        applyStimulus(1'b0, 3'b011, 32'h40, 32'h0, 1'b0, cyc, ld, mis, tmo);
        checkOutput("f3_011_flag", {31'b0, mis}, 32'h1);
        applyStimulus(1'b1, 3'b100, 32'h40, 32'h0, 1'b0, cyc, ld, mis, tmo);
        checkOutput("store_f3_100_flag", {31'b0, mis}, 32'h1);
        applyStimulus(1'b0, 3'b001, 32'h21, 32'h0, 1'b0, cyc, ld, mis, tmo);
        checkOutput("lh_odd_flag", {31'b0, mis}, 32'h1);

        readyDelay = 5;
        applyStimulus(1'b1, 3'b010, 32'h44, 32'h55AA_55AA, 1'b0, cyc, ld, mis, tmo);
        checkOutput("bp_store_latency", cyc, 32'd8);
        applyStimulus(1'b0, 3'b010, 32'h44, 32'h0, 1'b0, cyc, ld, mis, tmo);
        checkOutput("bp_load_latency", cyc, 32'd9);
        checkOutput("bp_load_data", ld, 32'h55AA_55AA);

        readyDelay = 0;
        noRvalid   = 1'b1;
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, cyc, ld, mis, tmo);
        checkOutput("to_load_flag", {31'b0, tmo}, 32'h1);
        checkOutput("to_load_data", ld, 32'h0);
        checkOutput("to_load_latency", cyc, 32'd10);
        noRvalid   = 1'b0;
        readyDelay = 100;
        applyStimulus(1'b1, 3'b010, 32'h50, 32'h1111_1111, 1'b1, cyc, ld, mis, tmo);
        checkOutput("to_store_flag", {31'b0, tmo}, 32'h1);
        checkOutput("to_store_latency", cyc, 32'd10);

        cur = makeTxn(1'b0, 3'b010, 32'h10, 32'h0);
        curTimeout = 1'b0;
        @(posedge clk);
        #1;
        curActive = 1'b1;
        bus.req_write = 1'b0; bus.req_f3 = 3'b010; bus.req_address = 32'h10; bus.req_valid = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("req_mem_valid", {31'b0, bus.mem_valid}, 32'h1);
        #2 rst_n = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        checkOutput("rst_req_mem_valid", {31'b0, bus.mem_valid}, 32'h0);
        checkOutput("rst_req_stall", {31'b0, bus.stall}, 32'h0);
        curActive = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        readyDelay = 0;
        noRvalid   = 1'b1;
        cur = makeTxn(1'b0, 3'b010, 32'h20, 32'h0);
        @(posedge clk);
        #1;
        curActive = 1'b1;
        bus.req_write = 1'b0; bus.req_f3 = 3'b010; bus.req_address = 32'h20; bus.req_valid = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("wait_mem_valid", {31'b0, bus.mem_valid}, 32'h0);
        checkOutput("wait_stall", {31'b0, bus.stall}, 32'h1);
        #2 rst_n = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        checkOutput("rst_wait_stall", {31'b0, bus.stall}, 32'h0);
        checkOutput("rst_wait_done", {31'b0, bus.done}, 32'h0);
        curActive = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        lateReq++;
        doneSeen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) doneSeen++;
        end
        checkOutput("late_rvalid_no_done", doneSeen, 32'd0);
        checkOutput("late_rvalid_load_data", bus.load_data, 32'h0);
        noRvalid = 1'b0;

        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, cyc, ld, mis, tmo);
        checkOutput("recover_lw_data", ld, 32'hDEAD_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
